// File: rtl/local_inject_arbiter_if.sv
// Requester-side and switch-side AXI-Stream bundle for the local injection arbiter.
// slave is the arbiter's view; master is the view of whatever drives the requesters and sinks out_*.
interface local_inject_arbiter_if #(
    parameter int BW   = 32,
    parameter int NREQ = 2
);
    localparam int BWB = BW / 8;

    logic [NREQ-1:0]     req_TVALID;
    logic [NREQ*BW-1:0]  req_TDATA;
    logic [NREQ*BWB-1:0] req_TKEEP;
    logic [NREQ-1:0]     req_TLAST;
    logic [NREQ-1:0]     req_TREADY;

    logic                out_TVALID;
    logic [BW-1:0]       out_TDATA;
    logic [BWB-1:0]      out_TKEEP;
    logic                out_TLAST;
    logic                out_TREADY;

    modport slave (
        input  req_TVALID, req_TDATA, req_TKEEP, req_TLAST, out_TREADY,
        output req_TREADY, out_TVALID, out_TDATA, out_TKEEP, out_TLAST
    );

    modport master (
        output req_TVALID, req_TDATA, req_TKEEP, req_TLAST, out_TREADY,
        input  req_TREADY, out_TVALID, out_TDATA, out_TKEEP, out_TLAST
    );
endinterface

// File: rtl/local_inject_arbiter.sv
// Packet-level round-robin arbiter sharing the tile switch local_in port between NREQ requesters.
// A grant is held from the first beat through the TLAST handshake; completed packets are counted per requester.
module local_inject_arbiter #(
    parameter int BW    = 32,
    parameter int BWB   = BW / 8,
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic                      clk_line,
    input  logic                      clk_line_rst_high,
    input  logic                      arb_enable,
    local_inject_arbiter_if.slave     bus,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic [NREQ*CNT_W-1:0]     pkt_count
);
    localparam int          GW = $clog2(NREQ);
    localparam int unsigned NR = NREQ;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state;
    logic [GW-1:0]    last_grant;
    logic [CNT_W-1:0] cnt [NREQ];
    logic             pick_valid;
    logic [GW-1:0]    pick;
    int unsigned      idx;
    logic             beat_last;

    // Round-robin search starting just after the last completed grant, with wrap.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        idx        = 0;
        for (int unsigned k = 1; k <= NR; k++) begin
            idx = (32'(last_grant) + k) % NR;
            if (!pick_valid && bus.req_TVALID[idx]) begin
                pick_valid = 1'b1;
                pick       = GW'(idx);
            end
        end
    end

    always_comb begin
        bus.out_TVALID = 1'b0;
        bus.out_TDATA  = '0;
        bus.out_TKEEP  = '0;
        bus.out_TLAST  = 1'b0;
        bus.req_TREADY = '0;
        if (state == LOCKED) begin
            bus.out_TVALID           = bus.req_TVALID[grant_id];
            bus.out_TDATA            = bus.req_TDATA[int'(grant_id) * BW +: BW];
            bus.out_TKEEP            = bus.req_TKEEP[int'(grant_id) * BWB +: BWB];
            bus.out_TLAST            = bus.req_TLAST[grant_id];
            bus.req_TREADY[grant_id] = bus.out_TREADY;
        end
    end

    assign beat_last = bus.out_TVALID & bus.out_TREADY & bus.out_TLAST;
    assign busy      = (state == LOCKED);

    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NREQ - 1);
            for (int unsigned i = 0; i < NR; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (arb_enable && pick_valid) begin
                        grant_id <= pick;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Lock is released only by the TLAST handshake; TVALID gaps and arb_enable are ignored.
                    if (beat_last) begin
                        cnt[grant_id] <= cnt[grant_id] + CNT_W'(1);
                        last_grant    <= grant_id;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pkt_count = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            pkt_count[i*CNT_W +: CNT_W] = cnt[i];
        end
    end
endmodule

// File: tb/tb_local_inject_arbiter.sv
// Directed bench for local_inject_arbiter: requester queues feed the DUT, a scoreboard of
// expected output beats (in predicted grant order) is compared as beats leave the arbiter.
module tb_local_inject_arbiter;
    localparam int BW    = 32;
    localparam int NREQ  = 2;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        beat_t beat;
        logic  src;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    arb_enable = 1'b1;
    logic                    busy;
    logic [0:0]              grant_id;
    logic [NREQ*CNT_W-1:0]   pkt_count;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    beat_cnt = 0;
    int    first_cyc = 0;
    int    last_cyc = 0;
    logic  mon_en = 1'b1;

    beat_t rq0[$];
    beat_t rq1[$];
    exp_t  sb[$];

    local_inject_arbiter_if #(.BW(BW), .NREQ(NREQ)) bus ();

    local_inject_arbiter #(
        .BW(BW),
        .BWB(BW / 8),
        .NREQ(NREQ),
        .CNT_W(CNT_W)
    ) dut (
        .clk_line(clk),
        .clk_line_rst_high(rst),
        .arb_enable(arb_enable),
        .bus(bus),
        .busy(busy),
        .grant_id(grant_id),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all();
        bus.req_TVALID[0]   = (rq0.size() != 0);
        bus.req_TDATA[31:0] = (rq0.size() != 0) ? rq0[0].data : '0;
        bus.req_TKEEP[3:0]  = (rq0.size() != 0) ? rq0[0].keep : '0;
        bus.req_TLAST[0]    = (rq0.size() != 0) ? rq0[0].last : 1'b0;
        bus.req_TVALID[1]    = (rq1.size() != 0);
        bus.req_TDATA[63:32] = (rq1.size() != 0) ? rq1[0].data : '0;
        bus.req_TKEEP[7:4]   = (rq1.size() != 0) ? rq1[0].keep : '0;
        bus.req_TLAST[1]     = (rq1.size() != 0) ? rq1[0].last : 1'b0;
    endtask

    task automatic add_pkt(input int src, input int n, input logic [31:0] base);
        for (int b = 0; b < n; b++) begin
            beat_t bt;
            bt.data = base + 32'(b);
            bt.keep = (b == n - 1) ? 4'h3 : 4'hF;
            bt.last = (b == n - 1);
            if (src == 0) rq0.push_back(bt);
            else          rq1.push_back(bt);
            sb.push_back('{beat: bt, src: 1'(src)});
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (n < 200 && !(sb.size() == 0 && rq0.size() == 0 && rq1.size() == 0 && busy === 1'b0)) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 64'(n < 200), 64'd1);
    endtask

    // Requester models: a beat is popped one edge after its handshake was seen.
    initial begin
        logic hs0, hs1;
        drive_all();
        forever begin
            @(negedge clk);
            hs0 = bus.req_TVALID[0] && bus.req_TREADY[0];
            hs1 = bus.req_TVALID[1] && bus.req_TREADY[1];
            @(posedge clk);
            #2;
            if (hs0 && rq0.size() != 0) void'(rq0.pop_front());
            if (hs1 && rq1.size() != 0) void'(rq1.pop_front());
            drive_all();
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst && bus.out_TVALID === 1'b1 && bus.out_TREADY === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat observed=%h expected=none", bus.out_TDATA);
                end
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (beat_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat_cnt++;
                chk("beat", 64'({grant_id, bus.req_TREADY, bus.out_TLAST, bus.out_TKEEP, bus.out_TDATA}),
                    64'({e.src, (e.src ? 2'b10 : 2'b01), e.beat.last, e.beat.keep, e.beat.data}));
            end
        end
    end

    initial begin
        bus.out_TREADY = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("reset_state", 64'({bus.out_TVALID, bus.out_TDATA, bus.out_TKEEP, bus.out_TLAST,
                               bus.req_TREADY, busy, grant_id, pkt_count}), 64'd0);

        // Single requester, 3 beats, one cycle arbitration latency.
        tick();
        rst = 1'b0;
        add_pkt(0, 3, 32'hA0);
        @(negedge clk);
        chk("lat_idle", 64'({bus.req_TVALID[0], bus.out_TVALID, busy}), 64'b100);
        @(negedge clk);
        chk("lat_grant", 64'({bus.req_TVALID[0], bus.out_TVALID, busy}), 64'b111);
        drain("single");
        chk("single_cnt", 64'(pkt_count), 64'h01);

        // Both requesters always valid: strict rotation with one bubble per packet.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        beat_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            add_pkt(0, 2, 32'h2000 + 32'(p * 16));
            add_pkt(1, 2, 32'h2100 + 32'(p * 16));
        end
        // Scoreboard must follow grant order 0,1,0,1,... rather than enqueue order per requester.
        sb.delete();
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < 2; s++) begin
                for (int b = 0; b < 2; b++) begin
                    beat_t bt;
                    bt.data = 32'h2000 + 32'(s * 256) + 32'(p * 16) + 32'(b);
                    bt.keep = (b == 1) ? 4'h3 : 4'hF;
                    bt.last = (b == 1);
                    sb.push_back('{beat: bt, src: 1'(s)});
                end
            end
        end
        drain("rotate");
        chk("rotate_beats", 64'(beat_cnt), 64'd12);
        chk("rotate_span", 64'(last_cyc - first_cyc), 64'd16);
        chk("rotate_cnt", 64'(pkt_count), 64'h33);

        // Back-pressure during req1's 4-beat packet.
        add_pkt(1, 4, 32'h3100);
        tick();
        chk("bp_locked", 64'(busy), 64'd1);
        @(negedge clk);
        chk("bp_c0", 64'({bus.req_TREADY, bus.out_TDATA}), 64'({2'b10, 32'h3100}));
        tick();
        bus.out_TREADY = 1'b0;
        @(negedge clk);
        chk("bp_c1", 64'({bus.req_TREADY, bus.out_TDATA}), 64'({2'b00, 32'h3101}));
        tick();
        @(negedge clk);
        chk("bp_c2", 64'({bus.req_TREADY, bus.out_TDATA}), 64'({2'b00, 32'h3101}));
        tick();
        bus.out_TREADY = 1'b1;
        @(negedge clk);
        chk("bp_c3", 64'({bus.req_TREADY, bus.out_TDATA}), 64'({2'b10, 32'h3101}));
        drain("bp");
        chk("bp_cnt", 64'(pkt_count), 64'h43);

        // arb_enable dropped after beat 2 of req0's packet; req1 waits until re-enabled.
        add_pkt(0, 4, 32'h4000);
        add_pkt(1, 4, 32'h4100);
        tick();
        tick();
        tick();
        arb_enable = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("dis_idle", 64'({busy, bus.out_TVALID, bus.req_TVALID, grant_id}), 64'b0_0_10_0);
            tick();
        end
        arb_enable = 1'b1;
        drain("dis");
        chk("dis_cnt", 64'(pkt_count), 64'h54);

        // Reset mid-packet: last grant was req0, so only a reset last_grant favours req0 again.
        add_pkt(0, 1, 32'h5000);
        drain("pre_rst");
        add_pkt(1, 4, 32'h5100);
        tick();
        tick();
        rst = 1'b1;
        mon_en = 1'b0;
        rq1.delete();
        sb.delete();
        tick();
        chk("rst_mid", 64'({bus.out_TVALID, busy, pkt_count, grant_id}), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        add_pkt(0, 1, 32'h5A00);
        add_pkt(1, 1, 32'h5B00);
        drain("post_rst");
        chk("post_rst_cnt", 64'(pkt_count), 64'h11);

        // Counter wrap: 17 single-beat packets from req0 with a 4-bit counter.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        beat_cnt = 0;
        for (int p = 0; p < 17; p++) add_pkt(0, 1, 32'h6000 + 32'(p));
        drain("wrap");
        chk("wrap_beats", 64'(beat_cnt), 64'd17);
        chk("wrap_span", 64'(last_cyc - first_cyc), 64'd32);
        chk("wrap_cnt", 64'(pkt_count), 64'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
